// File: rtl/decode_out_pkg_hdl.sv
// rtl/decode_out_pkg_hdl.sv - shared widths and bundle type for the decode output buffer
// Holds the default field widths, the packed decode bundle layout and the NOP constant.
package decode_out_pkg_hdl;

    localparam int IR_W     = 16;
    localparam int PC_W     = 16;
    localparam int E_CTRL_W = 6;
    localparam int W_CTRL_W = 2;

    // Field order matches the concatenation used by the top when packing a bundle.
    typedef struct packed {
        logic [IR_W-1:0]     ir;
        logic [PC_W-1:0]     npc;
        logic [E_CTRL_W-1:0] e_control;
        logic [W_CTRL_W-1:0] w_control;
        logic                mem_control;
    } decode_bundle_t;

    localparam decode_bundle_t DECODE_NOP = '0;

endpackage

// File: rtl/decode_out_fifo_mem.sv
// rtl/decode_out_fifo_mem.sv - DEPTH x WIDTH register array, one write port, async read
// Ports:
//   clock        rising-edge clock
//   we/waddr/wdata  write enable, address and bundle written at the clock edge
//   raddr/rdata     combinational read of the addressed entry
module decode_out_fifo_mem
    import decode_out_pkg_hdl::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(decode_bundle_t),
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage needs no reset: an entry is only ever read while the top
    // reports it as occupied, and empty reads are masked to a NOP.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/decode_out_buffer.sv
// rtl/decode_out_buffer.sv - FWFT decode-to-execute staging queue with flush and bubble counter
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   decode-side handshake; in_ready is !full from registered count
//   in_IR .. in_Mem_Control  bundle fields captured on push
//   flush               synchronous squash of every entry, beats push and pop
//   out_ready           execute accepts the head entry
//   en_decode           head entry valid
//   IR .. Mem_Control   head bundle fields, forced to zero when empty
//   count               occupied entries
//   bubble_cnt          saturating count of cycles with out_ready=1 and en_decode=0
module decode_out_buffer #(
    parameter int IR_W     = decode_out_pkg_hdl::IR_W,
    parameter int PC_W     = decode_out_pkg_hdl::PC_W,
    parameter int E_CTRL_W = decode_out_pkg_hdl::E_CTRL_W,
    parameter int W_CTRL_W = decode_out_pkg_hdl::W_CTRL_W,
    parameter int DEPTH    = 2,
    parameter int BCNT_W   = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IR_W-1:0]            in_IR,
    input  logic [PC_W-1:0]            in_npc,
    input  logic [E_CTRL_W-1:0]        in_E_control,
    input  logic [W_CTRL_W-1:0]        in_W_control,
    input  logic                       in_Mem_Control,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       en_decode,
    output logic [IR_W-1:0]            IR,
    output logic [PC_W-1:0]            npc_out,
    output logic [E_CTRL_W-1:0]        E_control,
    output logic [W_CTRL_W-1:0]        W_control,
    output logic                       Mem_Control,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [BCNT_W-1:0]          bubble_cnt
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH+1);
    localparam int BUNDLE_W = IR_W + PC_W + E_CTRL_W + W_CTRL_W + 1;

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [BUNDLE_W-1:0] wr_bundle;
    logic [BUNDLE_W-1:0] rd_bundle;
    logic [BUNDLE_W-1:0] head;
    logic                push;
    logic                pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign en_decode = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = en_decode & out_ready & ~flush;

    assign wr_bundle = {in_IR, in_npc, in_E_control, in_W_control, in_Mem_Control};

    decode_out_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (BUNDLE_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_bundle),
        .raddr (rd_ptr),
        .rdata (rd_bundle)
    );

    // Empty queue presents an all-zero NOP bubble to execute.
    assign head = en_decode ? rd_bundle : '0;
    assign {IR, npc_out, E_control, W_control, Mem_Control} = head;

    // Pointers are power-of-two wide so increments wrap without compare logic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (out_ready && !en_decode && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + BCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_out_buffer.sv
// tb/tb_decode_out_buffer.sv - directed self-checking bench for decode_out_buffer
module tb_decode_out_buffer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_IR;
    logic [15:0] in_npc;
    logic [5:0]  in_E_control;
    logic [1:0]  in_W_control;
    logic        in_Mem_Control;
    logic        flush;
    logic        out_ready;
    logic        en_decode;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_control;
    logic [1:0]  W_control;
    logic        Mem_Control;
    logic [1:0]  count;
    logic [15:0] bubble_cnt;

    logic        in_ready_b;
    logic        en_decode_b;
    logic [15:0] ir_b;
    logic [15:0] npc_b;
    logic [5:0]  e_b;
    logic [1:0]  w_b;
    logic        mem_b;
    logic [1:0]  count_b;
    logic [3:0]  bubble_cnt_b;

    int checks;
    int failures;

    decode_out_buffer #(.DEPTH(2), .BCNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_IR(in_IR), .in_npc(in_npc), .in_E_control(in_E_control),
        .in_W_control(in_W_control), .in_Mem_Control(in_Mem_Control),
        .flush(flush), .out_ready(out_ready), .en_decode(en_decode),
        .IR(IR), .npc_out(npc_out), .E_control(E_control), .W_control(W_control),
        .Mem_Control(Mem_Control), .count(count), .bubble_cnt(bubble_cnt)
    );

    decode_out_buffer #(.DEPTH(2), .BCNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_IR(in_IR), .in_npc(in_npc), .in_E_control(in_E_control),
        .in_W_control(in_W_control), .in_Mem_Control(in_Mem_Control),
        .flush(flush), .out_ready(out_ready), .en_decode(en_decode_b),
        .IR(ir_b), .npc_out(npc_b), .E_control(e_b), .W_control(w_b),
        .Mem_Control(mem_b), .count(count_b), .bubble_cnt(bubble_cnt_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [15:0] ir, input logic [15:0] npc);
        in_valid = 1'b1;
        in_IR    = ir;
        in_npc   = npc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_valid = 1'b1;
        in_IR = 16'hFFFF;
        in_npc = 16'hFFFF;
        in_E_control = 6'h3F;
        in_W_control = 2'h3;
        in_Mem_Control = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;

        // Reset held with in_valid asserted
        tick();
        tick();
        check("rst_en_decode", 32'(en_decode), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ir", 32'(IR), 32'h0);
        check("rst_bubble", 32'(bubble_cnt), 32'd0);

        // First push after reset appears one cycle later with all fields
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        in_E_control = 6'h2A;
        in_W_control = 2'h2;
        in_Mem_Control = 1'b1;
        push_one(16'h1234, 16'h3001);
        check("first_en_decode", 32'(en_decode), 32'd1);
        check("first_ir", 32'(IR), 32'h1234);
        check("first_npc", 32'(npc_out), 32'h3001);
        check("first_e_ctrl", 32'(E_control), 32'h2A);
        check("first_w_ctrl", 32'(W_control), 32'h2);
        check("first_mem_ctrl", 32'(Mem_Control), 32'h1);
        check("first_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_en_decode", 32'(en_decode), 32'd0);
        check("drain_ir_nop", 32'(IR), 32'h0);
        check("drain_e_nop", 32'(E_control), 32'h0);
        in_E_control = 6'h00;
        in_W_control = 2'h0;
        in_Mem_Control = 1'b0;

        // Fill to DEPTH, third bundle held off, then in-order drain
        push_one(16'hA000, 16'h0001);
        check("fill1_in_ready", 32'(in_ready), 32'd1);
        push_one(16'hB000, 16'h0002);
        check("fill2_count", 32'(count), 32'd2);
        check("fill2_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_IR = 16'hC000;
        in_npc = 16'h0003;
        tick();
        check("full_count", 32'(count), 32'd2);
        check("full_hold_ir", 32'(IR), 32'hA000);
        out_ready = 1'b1;
        tick();
        check("pop_a_count", 32'(count), 32'd1);
        check("pop_a_head", 32'(IR), 32'hB000);
        tick();
        in_valid = 1'b0;
        check("pop_b_count", 32'(count), 32'd1);
        check("pop_b_head", 32'(IR), 32'hC000);
        check("pop_b_npc", 32'(npc_out), 32'h0003);
        tick();
        out_ready = 1'b0;
        check("pop_c_count", 32'(count), 32'd0);

        // Simultaneous push/pop at count=1, wrapping the pointers
        push_one(16'hD000, 16'h0010);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            out_ready = 1'b1;
            in_IR = 16'h5000 + 16'(i);
            in_npc = 16'h0020 + 16'(i);
            tick();
            check("pair_count", 32'(count), 32'd1);
            check("pair_head", 32'(IR), 32'h5000 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("pair_drain_count", 32'(count), 32'd0);

        // Flush while full with push and pop requested
        push_one(16'hE001, 16'h0101);
        push_one(16'hE002, 16'h0102);
        check("preflush_count", 32'(count), 32'd2);
        flush = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_IR = 16'hEEEE;
        in_npc = 16'h0EEE;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_en_decode", 32'(en_decode), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_ir", 32'(IR), 32'h0);
        check("flush_npc", 32'(npc_out), 32'h0);

        // Flush at count=1 discards the concurrent push; next push is the new head
        push_one(16'hF001, 16'h0201);
        flush = 1'b1;
        in_valid = 1'b1;
        in_IR = 16'hF0FF;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush1_count", 32'(count), 32'd0);
        push_one(16'h7777, 16'h0301);
        check("post_flush_head", 32'(IR), 32'h7777);
        check("post_flush_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        check("no_bubble_yet", 32'(bubble_cnt), 32'd0);

        // Bubble counting and saturation (out_ready stays high, queue empty)
        for (int i = 0; i < 10; i++) tick();
        check("bubble_10", 32'(bubble_cnt), 32'd10);
        check("bubble4_10", 32'(bubble_cnt_b), 32'd10);
        for (int i = 0; i < 10; i++) tick();
        out_ready = 1'b0;
        check("bubble_20", 32'(bubble_cnt), 32'd20);
        check("bubble4_sat", 32'(bubble_cnt_b), 32'd15);

        // Asynchronous reset mid-cycle with two entries
        push_one(16'h9001, 16'h0401);
        push_one(16'h9002, 16'h0402);
        check("prerst_en_decode", 32'(en_decode), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_en_decode", 32'(en_decode), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_ir", 32'(IR), 32'h0);
        check("async_npc", 32'(npc_out), 32'h0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        check("async_bubble", 32'(bubble_cnt), 32'd0);
        check("async_bubble4", 32'(bubble_cnt_b), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_out_buffer.md
Name: decode_out_buffer

Overview:
Parametrised decode-to-execute staging buffer and the successor to the single-register decode output stage. It captures decoded bundles (IR, npc, execute/writeback/memory controls) into a DEPTH-entry first-word-fall-through queue, with valid/ready handshakes on both sides. It supports a pipeline flush and zeroes its outputs to a bubble (NOP) when empty. A saturating counter records bubbles seen by execute.

Parameters:
IR_W, 16, instruction register width
PC_W, 16, next-PC width
E_CTRL_W, 6, execute control width
W_CTRL_W, 2, writeback control width
DEPTH, 2, queue entries; power of two, >= 2
BCNT_W, 16, bubble counter width

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
in_valid  input  1  decode presents a bundle
in_ready  output  1  buffer can accept (= !full)
in_IR  input  IR_W  decoded instruction
in_npc  input  PC_W  next PC of instruction
in_E_control  input  E_CTRL_W  execute controls
in_W_control  input  W_CTRL_W  writeback controls
in_Mem_Control  input  1  memory control
flush  input  1  synchronous squash of all entries
out_ready  input  1  execute accepts head entry
en_decode  output  1  head entry valid (out_valid)
IR  output  IR_W  head instruction
npc_out  output  PC_W  head next PC
E_control  output  E_CTRL_W  head execute controls
W_control  output  W_CTRL_W  head writeback controls
Mem_Control  output  1  head memory control
count  output  $clog2(DEPTH+1)  occupied entries
bubble_cnt  output  BCNT_W  saturating count of cycles with out_ready=1 and en_decode=0

Behaviour:
- Reset (async assert, sync-safe deassert): wr_ptr=rd_ptr=0, count=0, bubble_cnt=0, en_decode=0, in_ready=1, all data outputs 0.
- push = in_valid & in_ready & !flush; pop = en_decode & out_ready & !flush.
- in_ready = (count != DEPTH), derived from registered count only; no combinational path from out_ready. Full with pop in the same cycle still gives in_ready=0.
- Pointers are log2(DEPTH) bits and wrap naturally. count += push - pop. Simultaneous push and pop leaves count unchanged, and both take effect.
- FWFT latency: a bundle pushed at edge N appears on outputs after edge N (en_decode=1 in cycle N+1). No same-cycle bypass.
- en_decode = (count != 0). When count==0, IR, npc_out, E_control, W_control and Mem_Control are forced to 0 (NOP bubble).
- Head outputs are stable while en_decode=1 and out_ready=0. Data order is strictly FIFO.
- flush (synchronous, highest priority): next edge sets count=0 and wr_ptr=rd_ptr=0. The concurrent push and pop are discarded. Next cycle en_decode=0 and in_ready=1. bubble_cnt is not cleared.
- bubble_cnt increments when out_ready=1 and en_decode=0, and saturates at 2^BCNT_W-1. It is cleared only by reset.
- Reset mid-operation discards all entries immediately (async); outputs go to reset values without waiting for a clock edge.

Decomposition:
- Shared package decode_out_pkg_hdl holds: default width constants (IR_W, PC_W, E_CTRL_W, W_CTRL_W), a packed typedef decode_bundle_t {IR, npc, E_control, W_control, Mem_Control}, and constant DECODE_NOP = '0.
- One sub-module, decode_out_fifo_mem: a DEPTH x $bits(decode_bundle_t) register array with write port and async read.
- Pointer, count, bubble masking and bubble counter logic stay in the top module.

Test Plan:
- Reset with in_valid=1 -> en_decode=0, count=0, in_ready=1, IR=0x0000. After deassert, push IR=0x1234, npc=0x3001 -> next cycle en_decode=1, IR=0x1234, npc_out=0x3001.
- DEPTH=2, out_ready=0, push 0xA000, 0xB000, 0xC000 on consecutive cycles -> count=2, in_ready=0 from the third cycle, 0xC000 held off. Then out_ready=1 -> pops 0xA000, then 0xB000, then 0xC000 in order.
- Count=1 with simultaneous push and pop -> count stays 1, next head is the pushed bundle; wrap-around verified over 5 pairs with no data loss.
- Count=2, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, en_decode=0, all data outputs 0, the pushed bundle never appears.
- Empty buffer, out_ready=1 held for 10 cycles -> bubble_cnt=10. With BCNT_W=4 held for 20 cycles -> bubble_cnt saturates at 15.
- Assert reset asynchronously mid-cycle with count=2 -> outputs zero before the next clock edge, and bubble_cnt=0.
